// File: rtl/capture_fifo_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo_sequencer_pkg
// Brief    : Shared state encoding, tags, FIFO geometry and word builders
//            for the capture FIFO sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package capture_fifo_sequencer_pkg;

    localparam int          c_fifo_depth = 10;
    localparam int          c_cnt_w      = 4;
    localparam logic [7:0]  c_hdr_tag    = 8'hA5;
    localparam logic [7:0]  c_trl_tag    = 8'h5A;

    // Field offsets inside header/trailer words
    localparam int          c_tag_lsb    = 24;
    localparam int          c_id_lsb     = 16;
    localparam int          c_cnt_lsb    = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PACK    = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_TRAILER = 3'd5
    } state_t;

    function automatic logic [31:0] make_header(input logic [7:0] tag, input logic [7:0] id);
        logic [31:0] w_word;
        w_word = '0;
        w_word[c_tag_lsb +: 8] = tag;
        w_word[c_id_lsb  +: 8] = id;
        return w_word;
    endfunction

    function automatic logic [31:0] make_trailer(input logic [7:0] tag, input logic [15:0] cnt);
        logic [31:0] w_word;
        w_word = '0;
        w_word[c_tag_lsb +: 8]  = tag;
        w_word[c_cnt_lsb +: 16] = cnt;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_fifo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo_sequencer_if
// Brief    : Pixel stream, FIFO write side and control/status bundle.
//            master = stimulus/software side, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface capture_fifo_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             arm;
    logic             abort;
    logic [7:0]       pix_data;
    logic             pix_valid;
    logic             pix_sof;
    logic             pix_eof;
    logic             fifo_rd;
    logic             fifo_wr;
    logic [31:0]      fifo_data;
    logic [CNT_W-1:0] fifo_level;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [7:0]       frame_id;

    modport master (
        output arm, abort, pix_data, pix_valid, pix_sof, pix_eof, fifo_rd,
        input  fifo_wr, fifo_data, fifo_level, busy, done, overflow, frame_id
    );

    modport slave (
        input  arm, abort, pix_data, pix_valid, pix_sof, pix_eof, fifo_rd,
        output fifo_wr, fifo_data, fifo_level, busy, done, overflow, frame_id
    );
endinterface
`default_nettype wire

// File: rtl/capture_fifo_sequencer_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo_sequencer_byte_packer
// Brief    : Little-endian byte-to-word packer: lane index plus accumulator.
//            o_last_lane says the next pushed byte completes o_word.
// Revision : 1.0 - initial release
// ============================================================================
module capture_fifo_sequencer_byte_packer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clr,
    input  wire logic        i_start,
    input  wire logic        i_push,
    input  wire logic [7:0]  i_byte,
    output logic             o_last_lane,
    output logic [31:0]      o_word,
    output logic [31:0]      o_partial
);
    logic [1:0]  r_idx;
    logic [31:0] r_acc;

    assign o_last_lane = (r_idx == 2'd3);
    assign o_word      = {i_byte, r_acc[23:0]};
    assign o_partial   = r_acc;

    // Lane index and accumulator; a completed word empties the accumulator so
    // a later flush sees unused lanes as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_idx <= 2'd0;
            r_acc <= '0;
        end else if (i_start) begin
            r_idx <= 2'd1;
            r_acc <= {24'h000000, i_byte};
        end else if (i_push) begin
            if (r_idx == 2'd3) begin
                r_idx <= 2'd0;
                r_acc <= '0;
            end else begin
                r_acc[{r_idx, 3'b000} +: 8] <= i_byte;
                r_idx <= r_idx + 2'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/capture_fifo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo_sequencer
// Brief    : Frames an ADV byte stream into header/data/trailer words for a
//            flagless capture FIFO, tracking its occupancy locally.
// Revision : 1.0 - initial release
// ============================================================================
module capture_fifo_sequencer
    import capture_fifo_sequencer_pkg::*;
#(
    parameter int         FIFO_DEPTH = c_fifo_depth,
    parameter int         CNT_W      = c_cnt_w,
    parameter logic [7:0] HDR_TAG    = c_hdr_tag,
    parameter logic [7:0] TRL_TAG    = c_trl_tag
) (
    input  wire logic                 clk1,
    input  wire logic                 rst,
    capture_fifo_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

    state_t           r_state, w_state_nxt;
    logic             r_fifo_wr, r_done, r_overflow, r_pend_eof;
    logic [31:0]      r_fifo_data;
    logic [CNT_W-1:0] r_level;
    logic [15:0]      r_dropped;
    logic [7:0]       r_frame_id;

    logic             w_wr, w_done, w_drop_inc, w_ovf_set, w_arm_acc, w_id_inc;
    logic             w_pend_set, w_pk_clr, w_pk_start, w_pk_push;
    logic [31:0]      w_wdata;
    logic             w_pk_last;
    logic [31:0]      w_pk_word, w_pk_partial;
    logic             w_rd_eff, w_room;

    assign w_rd_eff = bus.fifo_rd && (r_level != '0);
    // A write fits if there is a free cell or a read frees one this cycle
    assign w_room   = (r_level < c_depth) || bus.fifo_rd;

    capture_fifo_sequencer_byte_packer u_packer (
        .clk         (clk1),
        .rst         (rst),
        .i_clr       (w_pk_clr),
        .i_start     (w_pk_start),
        .i_push      (w_pk_push),
        .i_byte      (bus.pix_data),
        .o_last_lane (w_pk_last),
        .o_word      (w_pk_word),
        .o_partial   (w_pk_partial)
    );

    // Next-state, write decision and drop accounting; abort overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wdata     = r_fifo_data;
        w_done      = 1'b0;
        w_drop_inc  = 1'b0;
        w_ovf_set   = 1'b0;
        w_arm_acc   = 1'b0;
        w_id_inc    = 1'b0;
        w_pend_set  = 1'b0;
        w_pk_clr    = 1'b0;
        w_pk_start  = 1'b0;
        w_pk_push   = 1'b0;
        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_pk_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        w_state_nxt = ST_ARMED;
                        w_arm_acc   = 1'b1;
                        w_pk_clr    = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bus.pix_valid && bus.pix_sof) begin
                        w_state_nxt = ST_HEADER;
                        w_pk_start  = 1'b1;
                        w_pend_set  = bus.pix_eof;
                    end
                end
                ST_HEADER: begin
                    if (w_room) begin
                        w_wr    = 1'b1;
                        w_wdata = make_header(HDR_TAG, r_frame_id);
                        if (bus.pix_valid && !r_pend_eof) begin
                            w_pk_push   = 1'b1;
                            w_state_nxt = bus.pix_eof ? ST_FLUSH : ST_PACK;
                        end else begin
                            w_state_nxt = r_pend_eof ? ST_FLUSH : ST_PACK;
                        end
                    end else if (bus.pix_valid) begin
                        w_drop_inc = 1'b1;
                        w_pend_set = bus.pix_eof;
                    end
                end
                ST_PACK: begin
                    if (bus.pix_valid) begin
                        if (bus.pix_sof) begin
                            // Restart: partial word is lost and counted once
                            w_pk_start = 1'b1;
                            w_drop_inc = 1'b1;
                            if (bus.pix_eof) w_state_nxt = ST_FLUSH;
                        end else begin
                            w_pk_push = 1'b1;
                            if (w_pk_last) begin
                                if (w_room) begin
                                    w_wr    = 1'b1;
                                    w_wdata = w_pk_word;
                                end else begin
                                    w_drop_inc = 1'b1;
                                    w_ovf_set  = 1'b1;
                                end
                                if (bus.pix_eof) w_state_nxt = ST_TRAILER;
                            end else if (bus.pix_eof) begin
                                w_state_nxt = ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_room) begin
                        w_wr    = 1'b1;
                        w_wdata = w_pk_partial;
                    end else begin
                        w_drop_inc = 1'b1;
                        w_ovf_set  = 1'b1;
                    end
                    w_pk_clr    = 1'b1;
                    w_state_nxt = ST_TRAILER;
                end
                ST_TRAILER: begin
                    if (w_room) begin
                        w_wr        = 1'b1;
                        w_wdata     = make_trailer(TRL_TAG, r_dropped);
                        w_done      = 1'b1;
                        w_id_inc    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (bus.pix_valid) begin
                        w_drop_inc = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and registered write port / status outputs.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_done      <= 1'b0;
            r_frame_id  <= '0;
            r_pend_eof  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fifo_wr <= w_wr;
            r_done    <= w_done;
            if (w_wr) r_fifo_data <= w_wdata;
            if (w_id_inc) r_frame_id <= r_frame_id + 8'd1;
            if (w_arm_acc) r_pend_eof <= 1'b0;
            else if (w_pend_set) r_pend_eof <= 1'b1;
        end
    end

    // Occupancy counter and per-frame drop/overflow status.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_dropped  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && !w_rd_eff) r_level <= r_level + 1'b1;
            else if (!w_wr && w_rd_eff) r_level <= r_level - 1'b1;
            if (w_arm_acc) begin
                r_dropped  <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_drop_inc && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
                if (w_ovf_set) r_overflow <= 1'b1;
            end
        end
    end

    assign bus.fifo_wr    = r_fifo_wr;
    assign bus.fifo_data  = r_fifo_data;
    assign bus.fifo_level = r_level;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = r_done;
    assign bus.overflow   = r_overflow;
    assign bus.frame_id   = r_frame_id;
endmodule
`default_nettype wire

// File: tb/tb_capture_fifo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_fifo_sequencer
// Brief    : Directed frames with an expected-word queue drained by a
//            negedge monitor; status checked directly between frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_fifo_sequencer;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    capture_fifo_sequencer_if #(.CNT_W(4)) bus ();

    capture_fifo_sequencer u_dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 clk1 = ~clk1;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_done = 0;
    logic [31:0] exp_q[$];
    logic [31:0] r_exp_w;

    // Monitor: every fifo_wr pops one expected word
    always @(negedge clk1) begin
        if (bus.done) n_done = n_done + 1;
        if (bus.fifo_wr) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_miss = n_miss + 1;
                $display("FAIL fifo_wr_unexpected: actual %08h required no write", bus.fifo_data);
            end else begin
                r_exp_w = exp_q.pop_front();
                if (bus.fifo_data !== r_exp_w) begin
                    n_miss = n_miss + 1;
                    $display("FAIL fifo_data: actual %08h required %08h", bus.fifo_data, r_exp_w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic quiet(input int n);
        bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_eof = 1'b0;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.fifo_rd = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic eof, input logic rd);
        bus.pix_data = d; bus.pix_valid = 1'b1; bus.pix_sof = sof; bus.pix_eof = eof;
        bus.fifo_rd = rd;
        tick();
        bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_eof = 1'b0; bus.fifo_rd = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            bus.fifo_rd = 1'b1;
            tick();
        end
        bus.fifo_rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [7:0] b;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.pix_data = '0; bus.pix_valid = 1'b0;
        bus.pix_sof = 1'b0; bus.pix_eof = 1'b0; bus.fifo_rd = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check("rst_fifo_wr", 32'(bus.fifo_wr), 0);
        check("rst_level", 32'(bus.fifo_level), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_frame_id", 32'(bus.frame_id), 0);
        rst = 1'b0;
        quiet(2);

        // Nominal 8-byte frame
        exp_q.push_back(32'hA5000000); exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605); exp_q.push_back(32'h5A000000);
        do_arm();
        check("armed_busy", 32'(bus.busy), 1);
        for (int i = 1; i <= 8; i++) send(8'(i), i == 1, i == 8, 1'b0);
        quiet(3);
        check("t1_done_count", n_done, 1);
        check("t1_level", 32'(bus.fifo_level), 4);
        check("t1_frame_id", 32'(bus.frame_id), 1);
        check("t1_busy", 32'(bus.busy), 0);
        drain(5);
        check("drain_level_zero", 32'(bus.fifo_level), 0);

        // 6-byte frame with flush
        exp_q.push_back(32'hA5010000); exp_q.push_back(32'h14131211);
        exp_q.push_back(32'h00001615); exp_q.push_back(32'h5A000000);
        do_arm();
        for (int i = 1; i <= 6; i++) send(8'(8'h10 + i), i == 1, i == 6, 1'b0);
        quiet(3);
        check("t2_done_count", n_done, 2);
        check("t2_level", 32'(bus.fifo_level), 4);
        check("t2_frame_id", 32'(bus.frame_id), 2);
        drain(4);

        // Overflow: 48-byte frame, no reads
        exp_q.push_back(32'hA5020000);
        for (int k = 0; k < 9; k++) begin
            d0 = 8'hC0 + 4 * k;
            exp_q.push_back({8'(d0 + 3), 8'(d0 + 2), 8'(d0 + 1), 8'(d0)});
        end
        exp_q.push_back(32'h5A000003);
        do_arm();
        for (int i = 0; i < 48; i++) begin
            b = 8'(8'hC0 + i);
            send(b, i == 0, i == 47, 1'b0);
        end
        quiet(4);
        check("t3_level_full", 32'(bus.fifo_level), 10);
        check("t3_overflow", 32'(bus.overflow), 1);
        check("t3_trailer_wait_busy", 32'(bus.busy), 1);
        check("t3_no_done_yet", n_done, 2);
        drain(1);
        quiet(2);
        check("t3_level_after_rd", 32'(bus.fifo_level), 10);
        check("t3_done_count", n_done, 3);
        check("t3_frame_id", 32'(bus.frame_id), 3);

        // Simultaneous write and read at full
        exp_q.push_back(32'hA5030000); exp_q.push_back(32'h34333231);
        exp_q.push_back(32'h38373635); exp_q.push_back(32'h5A000000);
        do_arm();
        check("t4_overflow_cleared", 32'(bus.overflow), 0);
        for (int i = 1; i <= 8; i++) send(8'(8'h30 + i), i == 1, i == 8, (i == 2) || (i == 4) || (i == 8));
        bus.fifo_rd = 1'b1;
        tick();
        quiet(2);
        check("t4_level", 32'(bus.fifo_level), 10);
        check("t4_overflow", 32'(bus.overflow), 0);
        check("t4_frame_id", 32'(bus.frame_id), 4);
        drain(10);
        check("t4_drained", 32'(bus.fifo_level), 0);

        // Abort after 5 bytes, then a full frame reusing the frame_id
        exp_q.push_back(32'hA5040000); exp_q.push_back(32'h44434241);
        do_arm();
        for (int i = 1; i <= 5; i++) send(8'(8'h40 + i), i == 1, 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_abort_busy", 32'(bus.busy), 0);
        quiet(3);
        check("t5_no_done", n_done, 4);
        check("t5_frame_id", 32'(bus.frame_id), 4);
        exp_q.push_back(32'hA5040000); exp_q.push_back(32'h54535251);
        exp_q.push_back(32'h58575655); exp_q.push_back(32'h5A000000);
        do_arm();
        for (int i = 1; i <= 8; i++) send(8'(8'h50 + i), i == 1, i == 8, 1'b0);
        quiet(3);
        check("t5_done_count", n_done, 5);
        check("t5_frame_id_next", 32'(bus.frame_id), 5);
        check("t5_level", 32'(bus.fifo_level), 6);

        // Repeated SOF inside PACK
        exp_q.push_back(32'hA5050000); exp_q.push_back(32'h74737271);
        exp_q.push_back(32'h5A000001);
        do_arm();
        send(8'h61, 1'b1, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0, 1'b0);
        send(8'h63, 1'b0, 1'b0, 1'b0);
        send(8'h71, 1'b1, 1'b0, 1'b0);
        send(8'h72, 1'b0, 1'b0, 1'b0);
        send(8'h73, 1'b0, 1'b0, 1'b0);
        send(8'h74, 1'b0, 1'b1, 1'b0);
        quiet(3);
        check("t6_level", 32'(bus.fifo_level), 9);
        check("t6_frame_id", 32'(bus.frame_id), 6);

        // Asynchronous reset mid-PACK
        exp_q.push_back(32'hA5060000);
        do_arm();
        send(8'h81, 1'b1, 1'b0, 1'b0);
        send(8'h82, 1'b0, 1'b0, 1'b0);
        send(8'h83, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_level", 32'(bus.fifo_level), 0);
        check("arst_frame_id", 32'(bus.frame_id), 0);
        check("arst_fifo_wr", 32'(bus.fifo_wr), 0);
        check("arst_fifo_data", bus.fifo_data, 0);
        check("arst_overflow", 32'(bus.overflow), 0);
        tick();
        tick();
        rst = 1'b0;
        quiet(1);
        for (int i = 1; i <= 8; i++) send(8'(8'h90 + i), i == 1, i == 8, 1'b0);
        quiet(3);
        check("post_rst_idle", 32'(bus.busy), 0);
        check("post_rst_level", 32'(bus.fifo_level), 0);
        check("post_rst_done", n_done, 6);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/capture_fifo_sequencer.md
Name: capture_fifo_sequencer

Overview:
- Sits between the ADV pixel byte stream and the 32-bit internal capture FIFO.
- Packs bytes into 32-bit words, frames each capture with a header word and a trailer word, and issues the FIFO write strobes.
- Tracks FIFO occupancy from the write/read strobes, because the FIFO exports no full flag.
- Software arms one frame at a time; the block reports done/overflow status.

Parameters:
- FIFO_DEPTH, 10, number of 32-bit FIFO cells; occupancy limit.
- CNT_W, 4, occupancy counter width; must hold FIFO_DEPTH.
- HDR_TAG, 8'hA5, upper byte of header word.
- TRL_TAG, 8'h5A, upper byte of trailer word.

Ports:
- clk1  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  pulse: capture the next frame.
- abort  in  1  pulse: cancel the capture in progress.
- pix_data  in  8  ADV pixel byte.
- pix_valid  in  1  pix_data valid this cycle.
- pix_sof  in  1  first byte of frame; qualified by pix_valid.
- pix_eof  in  1  last byte of frame; qualified by pix_valid.
- fifo_rd  in  1  FIFO read strobe from the drain side; decrements occupancy.
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  32  FIFO write data.
- fifo_level  out  CNT_W  current occupancy.
- busy  out  1  high in ARMED..TRAILER.
- done  out  1  one-cycle pulse after the trailer is written.
- overflow  out  1  sticky; cleared by arm.
- frame_id  out  8  counts completed frames; wraps 255->0.

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, byte lane index 0, word accumulator 0, dropped count 0.
- Clocking: registered outputs; fifo_wr/fifo_data valid one cycle after the causing input.
- States: IDLE, ARMED, HEADER, PACK, FLUSH, TRAILER.
  - IDLE: arm -> ARMED; overflow cleared.
  - ARMED: pix_valid&pix_sof -> HEADER; pix_sof byte is kept as lane 0.
  - HEADER: one cycle; write {HDR_TAG, frame_id, 16'h0000} -> PACK.
  - PACK: each pix_valid byte goes into lane idx (lane 0 = bits[7:0], little-endian); idx wraps 3->0.
    - Lane 3 filled -> write the word.
    - pix_eof with idx!=3 -> FLUSH.
    - pix_eof with idx==3 -> write the word and go to TRAILER.
  - FLUSH: write the partial word, unused lanes zero -> TRAILER.
  - TRAILER: write {TRL_TAG, 8'h00, dropped[15:0]}; pulse done; frame_id+1 -> IDLE.
- Occupancy:
  - level+1 on a write, level-1 on fifo_rd, unchanged when both occur in the same cycle.
  - fifo_rd at level 0 is ignored.
- Full handling:
  - A data word that would be written at level==FIFO_DEPTH (with no concurrent fifo_rd) is dropped: no fifo_wr, dropped+1 (saturating at 16'hFFFF), overflow set.
  - Header and trailer are never dropped: the block waits in HEADER/TRAILER until level<FIFO_DEPTH or fifo_rd is high. Bytes arriving during that wait are discarded and counted in dropped.
- Repeated SOF: pix_sof in PACK restarts packing. The partial word is discarded with no extra header, and the event counts as 1 drop.
- Priority: abort > rst-free state logic.
  - abort in any non-IDLE state -> IDLE next cycle; no trailer, no done; frame_id unchanged; partial word lost.
- Re-arming: arm while busy is ignored.
- Reset mid-frame: immediate return to IDLE. The FIFO must be reset with the same reset, because the occupancy count restarts at 0.

Decomposition:
- Shared package (capture_pkg): state encoding constants, HDR_TAG/TRL_TAG, FIFO_DEPTH, header/trailer field offsets.
- Sub-module byte_packer: lane index, accumulator, word_ready/flush.
- FSM and occupancy logic stay in the top module.

Test Plan:
- Nominal 8-byte frame 01..08, no fifo_rd:
  - Writes A5000000, 04030201, 08070605, 5A000000.
  - done pulses once; fifo_level=4; frame_id=1.
- 6-byte frame 11..16:
  - Writes 14131211, then flush word 00001615.
  - Trailer 5A000000.
- Overflow, no reads, 48-byte frame:
  - fifo_level stays 10.
  - Words 10..12 are dropped (header plus 9 data words fill the FIFO).
  - overflow=1; trailer waits until one fifo_rd, then writes 5A000003.
- Simultaneous fifo_wr and fifo_rd at level 10 -> level stays 10; no drop.
- abort during PACK after 5 bytes -> IDLE next cycle; no done; no trailer; frame_id unchanged; next arm+frame writes header with the same frame_id.
- rst asserted asynchronously mid-PACK -> all outputs 0 without a clock edge; arm is required before any further writes.
